if_prefetch_buffer: RTL and testbench
=====================================

Name: if_prefetch_buffer

Overview:
Parametrised successor to the single-entry IF stage plus IF/ID register. It owns the fetch PC, reads instruction memory every cycle it has space, and queues {PC+4, instruction} pairs in a DEPTH-entry first-word-fall-through buffer. The ID stage consumes from the head under freeze control. A taken branch flushes every queued entry and redirects the fetch PC.

Parameters:
DEPTH, 4, number of buffered entries; power of two, >=2
ADDR_W, 32, PC / instruction-memory address width
INSTR_W, 32, instruction width
PC_STEP, 4, byte increment per fetch
RESET_PC, 0, fetch PC loaded on reset

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
branchTaken  in  1  redirect request from EXE; flushes buffer
branchAddress  in  ADDR_W  redirect target
freeze  in  1  hazard stall from ID; head must not be consumed
imemAddr  out  ADDR_W  instruction-memory address (= fetch PC register)
imemData  in  INSTR_W  instruction at imemAddr, valid in the same cycle (combinational ROM)
pc  out  ADDR_W  head entry's PC+PC_STEP; 0 when !valid
instruction  out  INSTR_W  head entry's instruction; 0 (bubble) when !valid
valid  out  1  head entry present (count != 0)
count  out  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Reset (rst=1 at edge): fetchPC<=RESET_PC; rdPtr, wrPtr, count <= 0. Outputs then read valid=0, pc=0, instruction=0, count=0, imemAddr=RESET_PC. Reset overrides every other input.
- Reset mid-operation discards all queued entries. No partial state survives.
- Outputs are combinational from registered state. imemAddr = fetchPC. pc, instruction and valid are muxed from the head slot with no added latency (FWFT).
- pop = valid & !freeze & !branchTaken.
- push = !branchTaken & (count < DEPTH | pop).
- On push: slot[wrPtr] <= {fetchPC+PC_STEP, imemData}; wrPtr++; fetchPC <= fetchPC+PC_STEP.
- On pop: rdPtr++.
- count update: +1 on push only, -1 on pop only, unchanged when both or neither.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Full (count=DEPTH) and no pop: no push, and fetchPC holds.
- Full with pop: push and pop occur in the same cycle, so count stays at DEPTH.
- Empty: valid=0 and the bubble outputs are presented. freeze is irrelevant while empty.
- Branch (branchTaken=1 at edge, rst=0): rdPtr, wrPtr, count <= 0; fetchPC <= {branchAddress[ADDR_W-1:2], 2'b00}. No push or pop occurs that cycle, and imemData is discarded.
- The first post-branch entry appears (valid=1) one cycle after the branch edge.
- Branch takes priority over freeze and over a full buffer.
- Latency: an instruction fetched at edge N is visible at the head after edge N when the buffer was empty. It is consumed at the first edge where valid & !freeze.
- After reset release, valid rises after the first clock edge. The buffer fills to DEPTH in DEPTH cycles if frozen.
- fetchPC arithmetic is modulo 2^ADDR_W and wraps silently at the top of the address space.
- Slot storage needs no reset; outputs are masked by valid.

Test Plan:
- Reset then freeze=0, ROM[i]=0xE000_0000+i, 6 cycles -> pc sequence 4,8,12,16,20,24; instruction sequence matches; valid=1 from cycle 1; count toggles 1 steady.
- freeze=1 for 6 cycles from reset, DEPTH=4 -> count 1,2,3,4,4,4; imemAddr holds at 16; head pc stays 4. Release freeze -> pc 4,8,12,16,20 on consecutive cycles, no gap or duplicate.
- Full buffer, freeze=0 for one cycle -> pop and push same edge; count stays 4; new tail pc=20.
- count=3, branchTaken=1, branchAddress=0x103 -> next cycle count=0, valid=0, pc=0, instruction=0, imemAddr=0x100. Following cycle head pc=0x104.
- branchTaken=1 together with freeze=1 on a full buffer -> flush still happens; imemAddr=branchAddress.
- rst asserted with count=3 mid-stream -> next cycle count=0, valid=0, imemAddr=RESET_PC. Rerun the first scenario with DEPTH=2 and DEPTH=8: pointer wrap is exercised over more than 3×DEPTH entries with no loss or duplication.

Source files
------------

// File: rtl/if_prefetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : if_prefetch_buffer
//  Purpose  : Instruction-fetch stage with a DEPTH-entry first-word-fall-through
//             queue of {PC+PC_STEP, instruction} pairs feeding the ID stage.
//             Owns the fetch PC, fetches whenever there is room, and flushes
//             and redirects on a taken branch.
//  Revision : 1.0 - initial release
// ============================================================================
module if_prefetch_buffer #(
  parameter int unsigned       DEPTH    = 4,
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INSTR_W  = 32,
  parameter int unsigned       PC_STEP  = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         branchTaken,
  input  logic [ADDR_W-1:0]            branchAddress,
  input  logic                         freeze,
  output logic [ADDR_W-1:0]            imemAddr,
  input  logic [INSTR_W-1:0]           imemData,
  output logic [ADDR_W-1:0]            pc,
  output logic [INSTR_W-1:0]           instruction,
  output logic                         valid,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  localparam logic [CNT_W-1:0]  c_depth_cnt = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] c_pc_step   = ADDR_W'(PC_STEP);
  // Redirect targets are forced word aligned by clearing the two low bits.
  localparam logic [ADDR_W-1:0] c_align     = ~ADDR_W'(3);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]   rd_ptr_q,   rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q,   wr_ptr_d;
  logic [CNT_W-1:0]   count_q,    count_d;

  // Slot payload is never reset; the head outputs are masked by valid.
  logic [ADDR_W-1:0]  slot_pc_q    [DEPTH];
  logic [INSTR_W-1:0] slot_instr_q [DEPTH];

  logic               w_valid;
  logic               w_pop;
  logic               w_push;
  logic [ADDR_W-1:0]  w_fetch_pc_next;
  logic [ADDR_W-1:0]  w_branch_target;

  assign w_valid         = (count_q != '0);
  assign w_fetch_pc_next = fetch_pc_q + c_pc_step;  // wraps modulo 2^ADDR_W
  assign w_branch_target = branchAddress & c_align;

  // A branch suppresses both queue operations; a full queue may still accept
  // a new fetch when the head leaves in the same cycle.
  assign w_pop  = w_valid & ~freeze & ~branchTaken;
  assign w_push = ~branchTaken & ((count_q < c_depth_cnt) | w_pop);

  // --------------------------------------------------------------------------
  // Outputs: combinational from registered state, head shown with no latency
  // --------------------------------------------------------------------------
  assign imemAddr    = fetch_pc_q;
  assign valid       = w_valid;
  assign count       = count_q;
  assign pc          = w_valid ? slot_pc_q[rd_ptr_q]    : '0;
  assign instruction = w_valid ? slot_instr_q[rd_ptr_q] : '0;

  // Next-state selection for fetch PC, pointers and occupancy.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;

    if (branchTaken) begin
      // Flush everything queued and restart fetching at the target.
      fetch_pc_d = w_branch_target;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (w_push) begin
        fetch_pc_d = w_fetch_pc_next;
        wr_ptr_d   = wr_ptr_q + PTR_W'(1);
      end
      if (w_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control registers: reset discards every queued entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Slot payload: capture the fetched word at the tail on every push.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      slot_pc_q[wr_ptr_q]    <= w_fetch_pc_next;
      slot_instr_q[wr_ptr_q] <= imemData;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_prefetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_prefetch_buffer
//  Purpose  : Drives three prefetch buffers (DEPTH 4, 2, 8) with identical
//             inputs and compares each against a list-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_if_prefetch_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        branchTaken = 1'b0;
  logic        freeze = 1'b0;
  logic [31:0] branchAddress = '0;

  logic [31:0] addr [3];
  logic [31:0] imem [3];
  logic [31:0] pcw  [3];
  logic [31:0] insw [3];
  logic        val  [3];
  logic [2:0]  cnt0;
  logic [1:0]  cnt1;
  logic [3:0]  cnt2;

  int n_cmp = 0;
  int n_err = 0;

  // Instruction ROM: word i holds 0xE000_0000 + i.
  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'hE000_0000 + (a >> 2);
  endfunction

  assign imem[0] = rom(addr[0]);
  assign imem[1] = rom(addr[1]);
  assign imem[2] = rom(addr[2]);

  if_prefetch_buffer #(.DEPTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .branchTaken(branchTaken), .branchAddress(branchAddress),
    .freeze(freeze), .imemAddr(addr[0]), .imemData(imem[0]), .pc(pcw[0]),
    .instruction(insw[0]), .valid(val[0]), .count(cnt0));

  if_prefetch_buffer #(.DEPTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .branchTaken(branchTaken), .branchAddress(branchAddress),
    .freeze(freeze), .imemAddr(addr[1]), .imemData(imem[1]), .pc(pcw[1]),
    .instruction(insw[1]), .valid(val[1]), .count(cnt1));

  if_prefetch_buffer #(.DEPTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .branchTaken(branchTaken), .branchAddress(branchAddress),
    .freeze(freeze), .imemAddr(addr[2]), .imemData(imem[2]), .pc(pcw[2]),
    .instruction(insw[2]), .valid(val[2]), .count(cnt2));

  initial forever #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: an ordered list per DUT, head at index 0.
  // ---------------------------------------------------------------------------
  logic [63:0] mbuf [3][8];
  int          mcnt [3];
  logic [31:0] mfpc [3];

  function automatic int depth_of(input int k);
    case (k)
      0:       return 4;
      1:       return 2;
      default: return 8;
    endcase
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        mcnt[k] = 0;
        mfpc[k] = 32'h0;
      end else if (branchTaken) begin
        mcnt[k] = 0;
        mfpc[k] = {branchAddress[31:2], 2'b00};
      end else begin
        bit do_pop, do_push;
        do_pop  = (mcnt[k] > 0) && !freeze;
        do_push = (mcnt[k] < depth_of(k)) || do_pop;
        if (do_pop) begin
          for (int j = 0; j < 7; j++) mbuf[k][j] = mbuf[k][j+1];
          mcnt[k]--;
        end
        if (do_push) begin
          mbuf[k][mcnt[k]] = {mfpc[k] + 32'd4, rom(mfpc[k])};
          mcnt[k]++;
          mfpc[k] = mfpc[k] + 32'd4;
        end
      end
    end
  endtask

  function automatic logic [100:0] exp_vec(input int k);
    logic        v;
    logic [63:0] head;
    v    = (mcnt[k] > 0);
    head = v ? mbuf[k][0] : 64'h0;
    return {v, 4'(mcnt[k]), head[63:32], head[31:0], mfpc[k]};
  endfunction

  function automatic logic [100:0] obs_vec(input int k);
    logic [3:0] c;
    case (k)
      0:       c = {1'b0, cnt0};
      1:       c = {2'b00, cnt1};
      default: c = cnt2;
    endcase
    return {val[k], c, pcw[k], insw[k], addr[k]};
  endfunction

  // Advance one clock: model consumes the pre-edge inputs, outputs sampled #1 later.
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; branchTaken = 1'b0; freeze = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1; branchTaken = 1'b1; branchAddress = 32'h40; freeze = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (obs_vec(k) !== exp_vec(k)) begin
        n_err++;
        $display("FAIL test_reset dut%0d: got %h want %h", k, obs_vec(k), exp_vec(k));
      end
    end
    n_cmp++;
    if ({val[0], cnt0, pcw[0], insw[0], addr[0]} !== {1'b0, 3'd0, 32'd0, 32'd0, 32'd0}) begin
      n_err++;
      $display("FAIL test_reset_const: got %b/%0d/%h/%h/%h want 0/0/0/0/0",
               val[0], cnt0, pcw[0], insw[0], addr[0]);
    end
    rst = 1'b0; branchTaken = 1'b0; freeze = 1'b0;
  endtask

  task automatic test_stream(input int cycles);
    do_reset();
    freeze = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (obs_vec(k) !== exp_vec(k)) begin
          n_err++;
          $display("FAIL test_stream dut%0d cyc%0d: got %h want %h", k, i, obs_vec(k), exp_vec(k));
        end
      end
      if (i < 6) begin
        n_cmp++;
        if ({val[0], cnt0, pcw[0], insw[0]} !== {1'b1, 3'd1, 32'd4 * (i + 1), 32'hE000_0000 + i}) begin
          n_err++;
          $display("FAIL test_stream_seq cyc%0d: got v%b c%0d pc %h ins %h want pc %h",
                   i, val[0], cnt0, pcw[0], insw[0], 32'd4 * (i + 1));
        end
      end
    end
  endtask

  task automatic test_freeze_fill();
    int exp_cnt [6] = '{1, 2, 3, 4, 4, 4};
    do_reset();
    freeze = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (obs_vec(k) !== exp_vec(k)) begin
          n_err++;
          $display("FAIL test_freeze_fill dut%0d cyc%0d: got %h want %h", k, i, obs_vec(k), exp_vec(k));
        end
      end
      n_cmp++;
      if ({cnt0, pcw[0]} !== {3'(exp_cnt[i]), 32'd4}) begin
        n_err++;
        $display("FAIL test_freeze_fill_cnt cyc%0d: got c%0d pc %h want c%0d pc 4",
                 i, cnt0, pcw[0], exp_cnt[i]);
      end
    end
    n_cmp++;
    if (addr[0] !== 32'd16) begin
      n_err++;
      $display("FAIL test_freeze_fill_addr: got %h want 10", addr[0]);
    end
    freeze = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (pcw[0] !== 32'd4 * (i + 2)) begin
        n_err++;
        $display("FAIL test_freeze_release cyc%0d: got pc %h want %h", i, pcw[0], 32'd4 * (i + 2));
      end
    end
  endtask

  task automatic test_full_pop();
    do_reset();
    freeze = 1'b1;
    repeat (5) tick();
    freeze = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (obs_vec(k) !== exp_vec(k)) begin
        n_err++;
        $display("FAIL test_full_pop dut%0d: got %h want %h", k, obs_vec(k), exp_vec(k));
      end
    end
    n_cmp++;
    if ({cnt0, pcw[0], addr[0]} !== {3'd4, 32'd8, 32'd20}) begin
      n_err++;
      $display("FAIL test_full_pop_const: got c%0d pc %h addr %h want c4 pc 8 addr 14",
               cnt0, pcw[0], addr[0]);
    end
    // Drain the queue to confirm the new tail entry holds pc 20.
    freeze = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (pcw[0] !== 32'd20) begin
      n_err++;
      $display("FAIL test_full_pop_tail: got pc %h want 14", pcw[0]);
    end
  endtask

  task automatic test_branch();
    do_reset();
    freeze = 1'b1;
    repeat (3) tick();
    branchTaken = 1'b1; branchAddress = 32'h103;
    tick();
    branchTaken = 1'b0;
    n_cmp++;
    if ({val[0], cnt0, pcw[0], insw[0], addr[0]} !== {1'b0, 3'd0, 32'd0, 32'd0, 32'h100}) begin
      n_err++;
      $display("FAIL test_branch_flush: got v%b c%0d pc %h ins %h addr %h want 0/0/0/0/100",
               val[0], cnt0, pcw[0], insw[0], addr[0]);
    end
    tick();
    n_cmp++;
    if ({val[0], pcw[0], insw[0]} !== {1'b1, 32'h104, 32'hE000_0040}) begin
      n_err++;
      $display("FAIL test_branch_head: got v%b pc %h ins %h want 1/104/e0000040",
               val[0], pcw[0], insw[0]);
    end
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (obs_vec(k) !== exp_vec(k)) begin
        n_err++;
        $display("FAIL test_branch dut%0d: got %h want %h", k, obs_vec(k), exp_vec(k));
      end
    end
  endtask

  task automatic test_branch_freeze_full();
    do_reset();
    freeze = 1'b1;
    repeat (5) tick();
    branchTaken = 1'b1; branchAddress = 32'h200;
    tick();
    branchTaken = 1'b0;
    n_cmp++;
    if ({val[0], cnt0, addr[0]} !== {1'b0, 3'd0, 32'h200}) begin
      n_err++;
      $display("FAIL test_branch_freeze_full: got v%b c%0d addr %h want 0/0/200",
               val[0], cnt0, addr[0]);
    end
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (obs_vec(k) !== exp_vec(k)) begin
        n_err++;
        $display("FAIL test_branch_freeze_full dut%0d: got %h want %h", k, obs_vec(k), exp_vec(k));
      end
    end
    freeze = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    freeze = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({val[0], cnt0, pcw[0], addr[0]} !== {1'b0, 3'd0, 32'd0, 32'd0}) begin
      n_err++;
      $display("FAIL test_reset_mid: got v%b c%0d pc %h addr %h want 0/0/0/0",
               val[0], cnt0, pcw[0], addr[0]);
    end
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (obs_vec(k) !== exp_vec(k)) begin
        n_err++;
        $display("FAIL test_reset_mid dut%0d: got %h want %h", k, obs_vec(k), exp_vec(k));
      end
    end
    freeze = 1'b0;
  endtask

  task automatic test_random(input int cycles);
    do_reset();
    for (int i = 0; i < cycles; i++) begin
      rst         = ($urandom_range(0, 59) == 0);
      branchTaken = ($urandom_range(0, 14) == 0);
      freeze      = ($urandom_range(0, 2) != 0) ? ($urandom_range(0, 1) == 1) : 1'b0;
      case ($urandom_range(0, 2))
        0:       branchAddress = $urandom;
        1:       branchAddress = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: branchAddress = 32'($urandom_range(0, 1023));
      endcase
      tick();
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (obs_vec(k) !== exp_vec(k)) begin
          n_err++;
          $display("FAIL test_random dut%0d cyc%0d: got %h want %h", k, i, obs_vec(k), exp_vec(k));
        end
      end
    end
    rst = 1'b0; branchTaken = 1'b0; freeze = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream(30);
    test_freeze_fill();
    test_full_pop();
    test_branch();
    test_branch_freeze_full();
    test_reset_mid();
    test_random(600);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
